// File: rtl/cdb_broadcast.sv
// CDB transmit side: per-source one-entry holding registers, round-robin arbiter,
// and a registered tag/data broadcast stage with flush and reset.

module cdb_hold_lane #(
  parameter int TAG_W  = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output logic              hold_v,
  output logic [TAG_W-1:0]  hold_tag,
  output logic [DATA_W-1:0] hold_data
);
  // A granted entry drains this edge, so the slot can refill in the same cycle.
  assign ready = !reset && !flush && (!hold_v || grant);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hold_v <= 1'b0;
    end else if (in_valid && ready) begin
      hold_v    <= 1'b1;
      hold_tag  <= in_tag;
      hold_data <= in_data;
    end else if (grant) begin
      hold_v <= 1'b0;
    end
  end
endmodule

module cdb_broadcast #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 10,
  parameter int DATA_W  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]  cdb_src
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]             hold_v;
  logic [NUM_SRC-1:0]             grant;
  logic [NUM_SRC-1:0][TAG_W-1:0]  hold_tag;
  logic [NUM_SRC-1:0][DATA_W-1:0] hold_data;
  logic [SRC_W-1:0]               ptr;
  logic [SRC_W-1:0]               gnt_idx;
  logic                           gnt_any;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    cdb_hold_lane #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (src_valid[g]),
      .in_tag   (src_tag[g*TAG_W +: TAG_W]),
      .in_data  (src_data[g*DATA_W +: DATA_W]),
      .grant    (grant[g]),
      .ready    (src_ready[g]),
      .hold_v   (hold_v[g]),
      .hold_tag (hold_tag[g]),
      .hold_data(hold_data[g])
    );
  end

  // First pending entry scanning upward from ptr, wrapping at NUM_SRC.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!gnt_any && hold_v[SRC_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      if (reset) ptr <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (gnt_any) begin
      ptr       <= (gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : gnt_idx + SRC_W'(1);
      cdb_valid <= 1'b1;
      cdb_tag   <= hold_tag[gnt_idx];
      cdb_data  <= hold_data[gnt_idx];
      cdb_src   <= gnt_idx;
    end else begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end
  end
endmodule

// File: tb/tb_cdb_broadcast.sv
// Directed + randomized bench for cdb_broadcast against a pending-slot reference model.

module tb_cdb_broadcast;
  localparam int N  = 4;
  localparam int TW = 10;
  localparam int DW = 64;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic [N-1:0]      src_valid, src_ready;
  logic [N*TW-1:0]   src_tag;
  logic [N*DW-1:0]   src_data;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [SW-1:0]     cdb_src;

  cdb_broadcast #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_tag(src_tag), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  // Reference: each source has at most one pending result; broadcasts go to the
  // first pending source at or after the rotating start position.
  bit            pv[N];
  logic [TW-1:0] pt[N];
  logic [DW-1:0] pd[N];
  int            mptr;
  bit            ev;
  logic [TW-1:0] et;
  logic [DW-1:0] ed;
  int            es;
  bit            stall[N];
  int            npass = 0;
  int            ntot  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (pv[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic set_src(input int i, input bit v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[i]           = v;
    src_tag[i*TW +: TW]    = t;
    src_data[i*DW +: DW]   = d;
  endtask

  // One clock: check ready before the edge, advance the model, check the CDB after it.
  task automatic tick();
    int w;
    bit rdy;
    #1;
    w = winner();
    for (int i = 0; i < N; i++) begin
      rdy = !reset && !flush && (!pv[i] || w == i);
      chk($sformatf("ready[%0d]", i), src_ready[i], rdy);
      stall[i] = src_valid[i] && !rdy;
    end
    if (reset || flush) begin
      for (int i = 0; i < N; i++) pv[i] = 0;
      if (reset) mptr = 0;
      ev = 0; et = '0; ed = '0; es = 0;
    end else begin
      if (w >= 0) begin
        ev = 1; et = pt[w]; ed = pd[w]; es = w; mptr = (w + 1) % N;
      end else begin
        ev = 0; et = '0; ed = '0; es = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && (!pv[i] || w == i)) begin
          pv[i] = 1; pt[i] = src_tag[i*TW +: TW]; pd[i] = src_data[i*DW +: DW];
        end else if (w == i) begin
          pv[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", cdb_valid, ev);
    chk("cdb_tag",   cdb_tag,   et);
    chk("cdb_data",  cdb_data,  ed);
    chk("cdb_src",   cdb_src,   es);
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  initial begin
    reset = 1; flush = 0; src_valid = '0; src_tag = '0; src_data = '0;
    mptr = 0; ev = 0; et = '0; ed = '0; es = 0;
    for (int i = 0; i < N; i++) begin pv[i] = 0; pt[i] = '0; pd[i] = '0; stall[i] = 0; end

    // Reset state
    tick(); tick();
    chk("reset_cdb_valid", cdb_valid, 0);
    chk("reset_cdb_tag", cdb_tag, 0);
    reset = 0;
    #1 chk("ready_after_reset", src_ready, 4'hF);

    // Single source, 2-edge latency
    set_src(2, 1, 10'h155, 64'hDEAD);
    tick(); idle();
    chk("single_not_yet", cdb_valid, 0);
    tick();
    chk("single_valid", cdb_valid, 1);
    chk("single_tag", cdb_tag, 10'h155);
    chk("single_data", cdb_data, 64'hDEAD);
    chk("single_src", cdb_src, 2);
    tick();
    chk("single_drop", cdb_valid, 0);

    // Round-robin after reset
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 1, TW'(i + 1), DW'(64'h100 + i));
    tick(); idle();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("rr_src", cdb_src, k);
      chk("rr_tag", cdb_tag, k + 1);
    end
    tick();

    // Pointer wrap: drive ptr to 3, then 3 and 0 pending
    set_src(2, 1, 10'h0AA, 64'h2); tick(); idle(); tick(); tick();
    set_src(3, 1, 10'h033, 64'h3); set_src(0, 1, 10'h300, 64'h4);
    tick(); idle();
    tick(); chk("wrap_first", cdb_src, 3);
    tick(); chk("wrap_second", cdb_src, 0);
    set_src(0, 1, 10'h010, 64'h5); set_src(1, 1, 10'h011, 64'h6);
    tick(); idle();
    tick(); chk("wrap_ptr1", cdb_src, 1);
    tick(); chk("wrap_then0", cdb_src, 0);
    tick();

    // Streaming on src 1
    for (int k = 0; k < 8; k++) begin
      set_src(1, 1, TW'(10'h3F0 + k), DW'(64'hA000 + k));
      tick();
      if (k > 0) chk("stream_tag", cdb_tag, 10'h3F0 + k - 1);
    end
    idle(); tick();
    chk("stream_last", cdb_tag, 10'h3F7);
    tick();

    // Contention: src 0 and 1 stream boundary tags
    set_src(0, 1, 10'h000, 64'h0);
    set_src(1, 1, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 8; k++) tick();
    idle(); tick(); tick(); tick();

    // Flush with 3 pending
    for (int i = 0; i < 3; i++) set_src(i, 1, TW'(10'h2A0 + i), DW'(i));
    tick(); idle();
    flush = 1; tick(); flush = 0;
    chk("flush_valid", cdb_valid, 0);
    for (int k = 0; k < 3; k++) begin tick(); chk("flush_quiet", cdb_valid, 0); end
    for (int i = 0; i < N; i++) set_src(i, 1, TW'(10'h050 + i), DW'(i));
    tick(); idle();
    for (int k = 0; k < N; k++) tick();

    // Reset with 3 pending
    for (int i = 1; i < 4; i++) set_src(i, 1, TW'(10'h1C0 + i), DW'(i));
    tick(); idle();
    reset = 1; tick(); reset = 0;
    chk("rst_valid", cdb_valid, 0);
    for (int k = 0; k < 3; k++) begin tick(); chk("rst_quiet", cdb_valid, 0); end
    for (int i = 0; i < N; i++) set_src(i, 1, TW'(10'h060 + i), DW'(i));
    tick(); idle();
    tick(); chk("rst_ptr0", cdb_src, 0);
    for (int k = 0; k < N; k++) tick();

    // Randomized traffic; a stalled source keeps its request stable
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!stall[i])
          set_src(i, ($urandom_range(0, 99) < 60), TW'($urandom_range(0, 1023)),
                  {$urandom, $urandom});
      flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    flush = 0; reset = 0; idle();
    for (int k = 0; k < 6; k++) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
